// File: rtl/sc_pkg.sv
// sc_pkg: shared next-PC select encodings, fetch FSM states and default vectors.
package sc_pkg;
  typedef enum logic [1:0] {PCS_SEQ = 2'b00, PCS_BR = 2'b01, PCS_JR = 2'b10, PCS_J = 2'b11} pcs_e;
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_FETCH = 2'b01, S_EXEC = 2'b10} state_e;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0008;
endpackage

// File: rtl/sc_npc.sv
// sc_npc: combinational next-PC selection and misaligned jr detection.
module sc_npc
  import sc_pkg::*;
(
  input  logic [31:0] i_pc4,
  input  logic [1:0]  i_pcsource,
  input  logic [15:0] i_imm,
  input  logic [25:0] i_addr,
  input  logic [31:0] i_ra,
  output logic [31:0] o_npc,
  output logic        o_misalign
);
  always_comb begin
    o_npc = i_pcsource == PCS_SEQ ? i_pc4 :
            i_pcsource == PCS_BR  ? i_pc4 + {{14{i_imm[15]}}, i_imm, 2'b00} :
            i_pcsource == PCS_JR  ? i_ra : {i_pc4[31:28], i_addr, 2'b00};
    o_misalign = i_pcsource == PCS_JR && i_ra[1:0] != 2'b00;
  end
endmodule

// File: rtl/sc_ifu.sv
// sc_ifu: single-cycle instruction fetch unit; fetches one word, holds it until the datapath commits.
module sc_ifu
  import sc_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  pcsource,
  input  logic [15:0] imm,
  input  logic [25:0] addr,
  input  logic [31:0] ra,
  input  logic        commit,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        misalign
);
  state_e      r_state, w_next;
  logic [31:0] r_pc, r_inst, w_npc;
  logic        r_misalign, w_misalign, w_take, w_commit;
  assign w_take   = r_state == S_FETCH && imem_ack;
  assign w_commit = r_state == S_EXEC && commit;
  sc_npc u_npc (
    .i_pc4      (pc4),
    .i_pcsource (pcsource),
    .i_imm      (imm),
    .i_addr     (addr),
    .i_ra       (ra),
    .o_npc      (w_npc),
    .o_misalign (w_misalign)
  );
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state == S_IDLE ? S_FETCH :
             w_take            ? S_EXEC  :
             w_commit          ? S_FETCH : r_state;
  end
  always_comb begin
    imem_req   = r_state == S_FETCH;
    inst_valid = r_state == S_EXEC;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_inst     <= 32'h0;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_commit && w_misalign;
      if (w_take) r_inst <= imem_rdata;
      if (w_commit) r_pc <= w_misalign ? EXC_VECTOR : w_npc;
    end
  end
  assign pc        = r_pc;
  assign pc4       = r_pc + 32'd4;
  assign imem_addr = r_pc;
  assign inst      = r_inst;
  assign misalign  = r_misalign;
endmodule

// File: tb/tb_sc_ifu.sv
// tb_sc_ifu: directed and random stimulus against a behavioural fetch/commit model.
module tb_sc_ifu;
  logic        clock = 1'b0, reset = 1'b1, commit = 1'b0, imem_ack = 1'b0;
  logic [1:0]  pcsource = 2'b00;
  logic [15:0] imm = 16'h0;
  logic [25:0] addr = 26'h0;
  logic [31:0] ra = 32'h0, imem_rdata = 32'h0;
  logic        imem_req, inst_valid, misalign;
  logic [31:0] imem_addr, inst, pc, pc4;
  int total = 0, bad = 0;
  int m_phase = 0;
  bit m_started = 0, m_mis = 0;
  logic [31:0] m_pc = 32'h0, m_inst = 32'h0;

  sc_ifu dut (
    .clock(clock), .reset(reset), .pcsource(pcsource), .imm(imm), .addr(addr), .ra(ra),
    .commit(commit), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .inst(inst), .inst_valid(inst_valid), .pc(pc), .pc4(pc4),
    .misalign(misalign)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Phase 0: waiting to start, 1: fetching, 2: holding an instruction for commit.
  always @(posedge clock) begin
    if (reset) begin
      m_started = 1; m_phase = 0; m_pc = 32'h0; m_inst = 32'h0; m_mis = 0;
    end else begin
      m_mis = 0;
      if (m_phase == 0) m_phase = 1;
      else if (m_phase == 1) begin
        if (imem_ack) begin m_inst = imem_rdata; m_phase = 2; end
      end else if (commit) begin
        int off;
        off = int'($signed(imm));
        m_phase = 1;
        case (pcsource)
          2'd0: m_pc = m_pc + 4;
          2'd1: m_pc = m_pc + 4 + off * 4;
          2'd2: if (ra % 4 != 0) begin m_pc = 32'h8; m_mis = 1; end else m_pc = ra;
          default: m_pc = ((m_pc + 4) & 32'hF000_0000) | (32'(addr) << 2);
        endcase
      end
    end
  end

  always @(negedge clock) begin
    if (m_started) begin
      chk("req", {31'b0, imem_req}, {31'b0, m_phase == 1});
      chk("valid", {31'b0, inst_valid}, {31'b0, m_phase == 2});
      chk("addr", imem_addr, m_pc);
      chk("pc", pc, m_pc);
      chk("pc4", pc4, m_pc + 4);
      chk("inst", inst, m_inst);
      chk("misalign", {31'b0, misalign}, {31'b0, m_mis});
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic exec_commit(input logic [1:0] ps, input logic [15:0] im, input logic [25:0] ad, input logic [31:0] r);
    pcsource = ps; imm = im; addr = ad; ra = r; commit = 1;
    step();
    commit = 0;
  endtask

  task automatic fetch_one(input logic [31:0] d);
    imem_ack = 1; imem_rdata = d;
    step();
    imem_ack = 0;
  endtask

  initial begin
    imem_ack = 1; imem_rdata = 32'h2001_0005;
    step(); step();
    reset = 0;
    @(negedge clock); chk("c0_req", {31'b0, imem_req}, 32'd0);
    step();
    @(negedge clock); chk("c1_req", {31'b0, imem_req}, 32'd1); chk("c1_addr", imem_addr, 32'h0);
    step();
    @(negedge clock); chk("c2_valid", {31'b0, inst_valid}, 32'd1); chk("c2_inst", inst, 32'h2001_0005);
    imem_ack = 0;
    exec_commit(2'd2, 16'h0, 26'h0, 32'h100);
    @(negedge clock); chk("jr_addr", imem_addr, 32'h100);
    fetch_one(32'h1111_1111);
    exec_commit(2'd1, 16'hFFFE, 26'h0, 32'h0);
    @(negedge clock); chk("br_neg", imem_addr, 32'h0FC);
    fetch_one(32'h2222_2222);
    exec_commit(2'd2, 16'h0, 26'h0, 32'h100);
    fetch_one(32'h3333_3333);
    exec_commit(2'd1, 16'h0003, 26'h0, 32'h0);
    @(negedge clock); chk("br_pos", imem_addr, 32'h110);
    fetch_one(32'h4444_4444);
    exec_commit(2'd2, 16'h0, 26'h0, 32'h8000_0010);
    fetch_one(32'h5555_5555);
    exec_commit(2'd3, 16'h0, 26'h000_0040, 32'h0);
    @(negedge clock); chk("j_addr", imem_addr, 32'h8000_0100);
    fetch_one(32'h6666_6666);
    exec_commit(2'd2, 16'h0, 26'h0, 32'h0000_0203);
    @(negedge clock); chk("exc_addr", imem_addr, 32'h8); chk("mis_hi", {31'b0, misalign}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clock);
      chk("stall_req", {31'b0, imem_req}, 32'd1);
      chk("stall_addr", imem_addr, 32'h8);
      chk("stall_valid", {31'b0, inst_valid}, 32'd0);
      if (i == 0) chk("mis_lo", {31'b0, misalign}, 32'd0);
    end
    exec_commit(2'd0, 16'h0, 26'h0, 32'h0);
    @(negedge clock); chk("stray_commit", pc, 32'h8);
    fetch_one(32'h7777_7777);
    reset = 1; commit = 1;
    step();
    reset = 0; commit = 0;
    @(negedge clock); chk("rst_pc", pc, 32'h0); chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    step();
    fetch_one(32'h8888_8888);
    exec_commit(2'd2, 16'h0, 26'h0, 32'hFFFF_FFFC);
    fetch_one(32'h9999_9999);
    exec_commit(2'd0, 16'h0, 26'h0, 32'h0);
    @(negedge clock); chk("wrap", imem_addr, 32'h0);
    for (int i = 0; i < 3000; i++) begin
      reset = $urandom_range(0, 63) == 0;
      imem_ack = $urandom_range(0, 1) == 1;
      commit = $urandom_range(0, 2) != 0;
      pcsource = 2'($urandom_range(0, 3));
      imm = 16'($urandom);
      addr = 26'($urandom);
      ra = $urandom;
      if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
      imem_rdata = $urandom;
      step();
    end
    reset = 0; commit = 0; imem_ack = 0;
    step();
    @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
